stream_writer_core: RTL and testbench

Synthesizable stream source: buffers up to MAX_BLOCK_SIZE words written through a simple push port and replays them in order on a valid/ready stream master port, with optional pseudo-random throttling of `valid`. It feeds stream sinks such as the Wishbone stream-to-memory DMA and lets the same block serve both as an on-chip traffic generator and as a rate-limited producer.

---
 rtl/stream_writer_core.sv | 124 ++++++++++++
 tb/tb_stream_writer_core.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_writer_core.sv
// Stream source: circular word buffer filled through a push port and replayed on a
// valid/ready master port. Define STREAM_WRITER_THROTTLE_EN for LFSR-driven valid gaps.
`timescale 1ns/1ps

module stream_writer_core #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned MAX_BLOCK_SIZE = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [WIDTH-1:0]                  wr_data_i,
  input  logic                              wr_en_i,
  output logic                              wr_full_o,
  output logic [$clog2(MAX_BLOCK_SIZE):0]   count_o,
  input  logic [7:0]                        throttle_i,
  output logic                              idle_o,
  output logic [WIDTH-1:0]                  stream_m_data_o,
  output logic                              stream_m_valid_o,
  input  logic                              stream_m_ready_i
);

  localparam int unsigned AW = $clog2(MAX_BLOCK_SIZE);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [MAX_BLOCK_SIZE];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             gap;
  logic             push;
  logic             load;

`ifdef STREAM_WRITER_THROTTLE_EN
  // Galois LFSR, taps 16,14,13,11 (mask 0xB400), free-running every cycle.
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]};
    if (lfsr_q[0]) begin
      lfsr_d = lfsr_d ^ 16'hB400;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign gap = (lfsr_q[7:0] < throttle_i);
`else
  logic unused_throttle;
  assign unused_throttle = ^throttle_i;
  assign gap             = 1'b0;
`endif

  assign push = wr_en_i & ~full_q;
  // A gap only blocks new loads; a word already presented stays until accepted.
  assign load = (~valid_q | stream_m_ready_i) & (count_q != '0) & ~gap;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    data_d   = data_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end

    if (load) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      valid_d  = 1'b1;
      data_d   = mem_q[rd_ptr_q];
    end else if (valid_q && stream_m_ready_i) begin
      valid_d  = 1'b0;
    end

    case ({push, load})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    full_d = (count_d == CW'(MAX_BLOCK_SIZE));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign wr_full_o        = full_q;
  assign count_o          = count_q;
  assign stream_m_valid_o = valid_q;
  assign stream_m_data_o  = data_q;
  assign idle_o           = (count_q == '0) & ~valid_q;

endmodule

// File: tb/tb_stream_writer_core.sv
// Scoreboard bench for stream_writer_core: pushes enqueue expected words, a negedge
// monitor pops and compares every stream handshake.
`timescale 1ns/1ps

module tb_stream_writer_core;

  localparam int W  = 32;
  localparam int D  = 32;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  wr_data;
  logic          wr_en;
  logic          wr_full;
  logic [CW-1:0] count;
  logic [7:0]    throttle;
  logic          idle;
  logic [W-1:0]  data;
  logic          valid;
  logic          ready;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int hs_count = 0;
  int cyc = 0;
  bit meas = 0;
  int meas_hs = 0;
  int first_cyc = 0;
  int last_cyc = 0;

  always #5 clk = ~clk;

  stream_writer_core #(.WIDTH(W), .MAX_BLOCK_SIZE(D)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .wr_data_i        (wr_data),
    .wr_en_i          (wr_en),
    .wr_full_o        (wr_full),
    .count_o          (count),
    .throttle_i       (throttle),
    .idle_o           (idle),
    .stream_m_data_o  (data),
    .stream_m_valid_o (valid),
    .stream_m_ready_i (ready)
  );

  // Monitor: a handshake seen here completes on the following rising edge.
  always @(negedge clk) begin
    logic [W-1:0] e;
    cyc++;
    if (rst_n && valid && ready) begin
      hs_count++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL stream_word: got %08h required none (unexpected word)", data);
      end else begin
        e = exp_q.pop_front();
        if (data !== e) begin
          n_err++;
          $display("FAIL stream_word: got %08h required %08h", data, e);
        end
      end
      if (meas) begin
        if (meas_hs == 0) first_cyc = cyc;
        last_cyc = cyc;
        meas_hs++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [W-1:0] d, input bit accept);
    wr_data = d;
    wr_en   = 1'b1;
    if (accept) exp_q.push_back(d);
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic drain(input bit rnd);
    int k = 0;
    while (!(exp_q.size() == 0 && idle) && k < 400) begin
      if (rnd) ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      k++;
    end
    ready = 1'b1;
    check("drain_done", 64'(exp_q.size() == 0 && idle), 64'd1);
  endtask

  initial begin
    int hs0;
    int sent;
    int guard;
    int span;
    int pm;

    rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; ready = 1'b0; throttle = 8'd0;
    repeat (2) @(posedge clk); #1;
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_data",  64'(data),  64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_full",  64'(wr_full), 64'd0);
    check("rst_idle",  64'(idle),  64'd1);

    // Basic three-word stream, ready high
    rst_n = 1'b1; ready = 1'b1;
    @(posedge clk); #1;
    hs0 = hs_count;
    push(32'h11111111, 1);
    check("lat_first_edge_valid", 64'(valid), 64'd0);
    push(32'h22222222, 1);
    check("lat_valid_n1", 64'(valid), 64'd1);
    check("lat_data_n1",  64'(data),  64'h11111111);
    push(32'h33333333, 1);
    check("stream_valid_c2", 64'(valid), 64'd1);
    @(posedge clk); #1;
    check("stream_valid_c3", 64'(valid), 64'd1);
    @(posedge clk); #1;
    check("basic_idle", 64'(idle), 64'd1);
    check("basic_hs",   64'(hs_count - hs0), 64'd3);

    // Fill: 34 pushes with ready low, last one dropped
    ready = 1'b0;
    for (int i = 0; i < 34; i++) begin
      push(32'h1000 + 32'(i), i < 33);
      if (i == 31) begin
        check("fill_count_31", 64'(count), 64'd31);
        check("fill_notfull",  64'(wr_full), 64'd0);
      end
      if (i == 32) begin
        check("fill_count_32", 64'(count), 64'd32);
        check("fill_full",     64'(wr_full), 64'd1);
      end
      if (i == 33) begin
        check("drop_count", 64'(count), 64'd32);
        check("drop_full",  64'(wr_full), 64'd1);
      end
    end
    check("fill_head_data", 64'(data), 64'h1000);
    ready = 1'b1;
    drain(0);

    // Backpressure hold
    ready = 1'b0;
    push(32'hDEADBEEF, 1);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 64'(valid), 64'd1);
      check("bp_data",  64'(data),  64'hDEADBEEF);
      @(posedge clk); #1;
    end
    ready = 1'b1;
    @(posedge clk); #1;
    check("bp_done_valid", 64'(valid), 64'd0);
    check("bp_done_queue", 64'(exp_q.size()), 64'd0);

    // Wrap-around with random ready, bursts below buffer depth
    for (int b = 0; b < 5; b++) begin
      for (int j = 0; j < 20; j++) begin
        ready = 1'($urandom_range(0, 1));
        push(32'(b * 20 + j), 1);
      end
      drain(1);
    end

    // Throughput / throttle: pace pushes on the full flag, 1000 words
    throttle = 8'd26; ready = 1'b1;
    meas_hs = 0; meas = 1;
    sent = 0; guard = 0;
    while (sent < 1000 && guard < 5000) begin
      if (!wr_full) begin
        wr_en = 1'b1; wr_data = 32'h5000_0000 + 32'(sent);
        exp_q.push_back(wr_data);
        sent++;
      end else begin
        wr_en = 1'b0;
      end
      @(posedge clk); #1;
      guard++;
    end
    wr_en = 1'b0;
    check("thr_all_sent", 64'(sent), 64'd1000);
    drain(0);
    meas = 0;
    throttle = 8'd0;
    check("thr_hs", 64'(meas_hs), 64'd1000);
    span = last_cyc - first_cyc + 1;
`ifdef STREAM_WRITER_THROTTLE_EN
    pm = (span > 0) ? (1000000 / span) : 0;
    n_cmp++;
    if (pm < 850 || pm > 950) begin
      n_err++;
      $display("FAIL thr_fraction: got %0d per mille required 850..950", pm);
    end
`else
    pm = 0;
    check("thr_span", 64'(span), 64'd1000);
`endif

    // Reset mid-stream with ten words queued
    ready = 1'b0;
    for (int i = 0; i < 10; i++) push(32'hA000 + 32'(i), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    check("mrst_valid", 64'(valid), 64'd0);
    check("mrst_count", 64'(count), 64'd0);
    check("mrst_idle",  64'(idle),  64'd1);
    rst_n = 1'b1; ready = 1'b1;
    hs0 = hs_count;
    repeat (10) @(posedge clk);
    #1;
    check("mrst_no_stale", 64'(hs_count - hs0), 64'd0);
    check("mrst_idle_after", 64'(idle), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
